// File: rtl/cpu_ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the CPU system bus (master side) and cpu_ahb_sram_slave.
// Latency: none (wires only).
// Backpressure: hready from the slave stalls the master; hreadyin is the bus-wide HREADY.
// Ports: master drives hsel/haddr/htrans/hwrite/hsize/hburst/hprot/hwdata/hreadyin,
//        slave returns hrdata/hready/hresp.
interface cpu_ahb_sram_slave_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hreadyin;
   logic [31:0] hrdata;
   logic        hready;
   logic [1:0]  hresp;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyin,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyin,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/cpu_ahb_sram_slave.sv
// AHB-Lite slave onto a single-port sync SRAM with a one-entry posted write buffer.
// Latency: zero-wait reads (data in the cycle after the address phase), zero-wait writes.
// Backpressure: one wait state when a write data phase finds the buffer full and a read
//   address phase blocks the drain; two-cycle ERROR response for illegal transfers.
// Ports: cpu_clk, pad_cpu_rst_b (async, active-low), ahb (slave modport of
//   cpu_ahb_sram_slave_if), sram_ce/we/addr/wdata/wbe out, sram_rdata in.
// Optional feature: define CPU_AHB_SRAM_ERR_RESP_EN to enable illegal-transfer detection
//   and the ERROR response; otherwise hresp is always OKAY and upper address bits alias.
module cpu_ahb_sram_slave #(
   parameter int ADDR_W   = 14,
   parameter int REGION_W = 20
) (
   input  logic                cpu_clk,
   input  logic                pad_cpu_rst_b,
   cpu_ahb_sram_slave_if.slave ahb,
   output logic                sram_ce,
   output logic                sram_we,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [31:0]         sram_wdata,
   output logic [3:0]          sram_wbe,
   input  logic [31:0]         sram_rdata
);

   logic [ADDR_W-1:0] a_word;
   logic [3:0]        a_be;
   logic              illegal;
   logic              acc;
   logic              rd_issue;
   logic              wr_acc;
   logic              rd_req;
   logic              conflict;
   logic              drain;
   logic              load;
   logic              err_wait;
   logic [1:0]        rsp;
   logic [31:0]       hrdata;

   logic              wr_dp_q,    wr_dp_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [3:0]        wr_be_q,    wr_be_d;
   logic              rd_dp_q,    rd_dp_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
   logic              buf_vld_q,  buf_vld_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [31:0]       buf_data_q, buf_data_d;
   logic [3:0]        buf_be_q,   buf_be_d;

   logic unused_bits;
   assign unused_bits = ^{ahb.hburst, ahb.hprot, ahb.haddr};

   // Address-phase decode: word address and lane enables.
   always_comb begin
      a_word = ahb.haddr[ADDR_W+1:2];
      a_be   = 4'b1111;
      case (ahb.hsize)
         3'd0:    a_be = 4'b0001 << ahb.haddr[1:0];
         3'd1:    a_be = 4'b0011 << {ahb.haddr[1], 1'b0};
         default: a_be = 4'b1111;
      endcase
   end

`ifdef CPU_AHB_SRAM_ERR_RESP_EN
   typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} rsp_st_t;

   rsp_st_t    st_q;
   logic [1:0] hresp_q;
   logic       err_wait_q;

   assign illegal = (ahb.hsize > 3'd2)
                  | ((ahb.hsize == 3'd1) & ahb.haddr[0])
                  | ((ahb.hsize == 3'd2) & (ahb.haddr[1:0] != 2'b00))
                  | (ahb.haddr[REGION_W-1:ADDR_W+2] != '0);

   // Response FSM: ERR1 stalls with ERROR, ERR2 completes it. An illegal transfer
   // accepted during ERR2 restarts the sequence.
   always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         st_q       <= ST_OKAY;
         hresp_q    <= 2'b00;
         err_wait_q <= 1'b0;
      end else begin
         case (st_q)
            ST_ERR1: begin
               st_q       <= ST_ERR2;
               hresp_q    <= 2'b01;
               err_wait_q <= 1'b0;
            end
            default: begin
               if (acc && illegal) begin
                  st_q       <= ST_ERR1;
                  hresp_q    <= 2'b01;
                  err_wait_q <= 1'b1;
               end else begin
                  st_q       <= ST_OKAY;
                  hresp_q    <= 2'b00;
                  err_wait_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign err_wait = err_wait_q;
   assign rsp      = hresp_q;
`else
   localparam int unused_region_w = REGION_W;
   assign illegal  = 1'b0;
   assign err_wait = 1'b0;
   assign rsp      = 2'b00;
`endif

   // rd_req deliberately excludes hready/hreadyin: with a single slave hreadyin is our
   // own hready, so using it here would close a combinational loop.
   assign rd_req   = ahb.hsel & ahb.htrans[1] & ~ahb.hwrite & ~illegal;
   assign conflict = wr_dp_q & buf_vld_q & rd_req;
   assign acc      = ahb.hsel & ahb.hreadyin & ahb.htrans[1] & ahb.hready;
   assign rd_issue = acc & ~ahb.hwrite & ~illegal;
   assign wr_acc   = acc &  ahb.hwrite & ~illegal;
   // During a conflict hready is low, so no read issues and the old entry drains.
   assign drain    = buf_vld_q & ~rd_issue;
   assign load     = wr_dp_q & ~conflict;

   assign ahb.hready = ~conflict & ~err_wait;
   assign ahb.hresp  = rsp;
   assign ahb.hrdata = hrdata;

   always_comb begin
      wr_dp_d    = wr_acc | (wr_dp_q & conflict);
      wr_addr_d  = wr_acc ? a_word : wr_addr_q;
      wr_be_d    = wr_acc ? a_be   : wr_be_q;
      rd_dp_d    = rd_issue;
      rd_addr_d  = rd_issue ? a_word : rd_addr_q;
      buf_vld_d  = buf_vld_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      buf_be_d   = buf_be_q;
      if (drain) begin
         buf_vld_d = 1'b0;
      end
      // Load after drain so a same-cycle drain+load leaves the new entry valid.
      if (load) begin
         buf_vld_d  = 1'b1;
         buf_addr_d = wr_addr_q;
         buf_data_d = ahb.hwdata;
         buf_be_d   = wr_be_q;
      end
   end

   // Single SRAM port: read issue wins, the buffer drains otherwise.
   always_comb begin
      sram_ce    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wbe   = '0;
      if (rd_issue) begin
         sram_ce   = 1'b1;
         sram_addr = a_word;
      end else if (drain) begin
         sram_ce    = 1'b1;
         sram_we    = 1'b1;
         sram_addr  = buf_addr_q;
         sram_wdata = buf_data_q;
         sram_wbe   = buf_be_q;
      end
   end

   // Read data phase: lanes still pending in the buffer override stale SRAM data.
   always_comb begin
      hrdata = '0;
      if (rd_dp_q) begin
         for (int i = 0; i < 4; i++) begin
            if (buf_vld_q && (buf_addr_q == rd_addr_q) && buf_be_q[i]) begin
               hrdata[8*i +: 8] = buf_data_q[8*i +: 8];
            end else begin
               hrdata[8*i +: 8] = sram_rdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         wr_dp_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_be_q    <= '0;
         rd_dp_q    <= 1'b0;
         rd_addr_q  <= '0;
         buf_vld_q  <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         buf_be_q   <= '0;
      end else begin
         wr_dp_q    <= wr_dp_d;
         wr_addr_q  <= wr_addr_d;
         wr_be_q    <= wr_be_d;
         rd_dp_q    <= rd_dp_d;
         rd_addr_q  <= rd_addr_d;
         buf_vld_q  <= buf_vld_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         buf_be_q   <= buf_be_d;
      end
   end

endmodule

// File: tb/tb_cpu_ahb_sram_slave.sv
// Directed bench for cpu_ahb_sram_slave: one table row per bus cycle, plus hand-written
// error-response / aliasing and reset-with-pending-write sequences.
// A behavioural SRAM model supplies read data one cycle after each read access.
module tb_cpu_ahb_sram_slave;
   localparam int ADDR_W = 14;
   localparam logic [1:0] T_ID = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SQ = 2'b11;

   typedef struct {
      logic [1:0]        t;
      logic              w;
      logic [2:0]        s;
      logic [31:0]       a;
      logic [31:0]       d;
      logic              rdy;
      logic [31:0]       rd;
      logic              ce;
      logic              we;
      logic [ADDR_W-1:0] sa;
      logic [31:0]       wd;
      logic [3:0]        be;
   } vec_t;

   logic              cpu_clk;
   logic              pad_cpu_rst_b;
   logic              sram_ce;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [3:0]        sram_wbe;
   logic [31:0]       sram_rdata;
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic              pl_en;
   logic [ADDR_W-1:0] pl_addr;
   logic [31:0]       pl_data;
   int                nvec = 0;
   int                nmis = 0;
   vec_t              vt[$];

   cpu_ahb_sram_slave_if bus ();
   assign bus.hreadyin = bus.hready;

   cpu_ahb_sram_slave #(.ADDR_W(ADDR_W), .REGION_W(20)) u_dut (
      .cpu_clk       (cpu_clk),
      .pad_cpu_rst_b (pad_cpu_rst_b),
      .ahb           (bus),
      .sram_ce       (sram_ce),
      .sram_we       (sram_we),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .sram_wbe      (sram_wbe),
      .sram_rdata    (sram_rdata)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   // SRAM model with a preload port used only while the DUT is in reset.
   always @(posedge cpu_clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (sram_ce) begin
         if (sram_we) begin
            for (int i = 0; i < 4; i++)
               if (sram_wbe[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   function automatic vec_t v(input logic [1:0] t, input logic w, input logic [2:0] s,
                              input logic [31:0] a, input logic [31:0] d, input logic rdy,
                              input logic [31:0] rd, input logic ce, input logic we,
                              input logic [ADDR_W-1:0] sa, input logic [31:0] wd,
                              input logic [3:0] be);
      vec_t r;
      r.t = t; r.w = w; r.s = s; r.a = a; r.d = d; r.rdy = rdy; r.rd = rd;
      r.ce = ce; r.we = we; r.sa = sa; r.wd = wd; r.be = be;
      return r;
   endfunction

   task automatic drive(input logic [1:0] t, input logic w, input logic [2:0] s,
                        input logic [31:0] a, input logic [31:0] d);
      bus.hsel   = 1'b1;
      bus.htrans = t;
      bus.hwrite = w;
      bus.hsize  = s;
      bus.haddr  = a;
      bus.hwdata = d;
   endtask

   task automatic tick;
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic rdy, input logic [1:0] resp,
                          input logic [31:0] rd, input logic ce, input logic we,
                          input logic [ADDR_W-1:0] sa, input logic [31:0] wd,
                          input logic [3:0] be);
      nvec++;
      chk({nm, " hready"},     32'(bus.hready), 32'(rdy));
      chk({nm, " hresp"},      32'(bus.hresp),  32'(resp));
      chk({nm, " hrdata"},     bus.hrdata,      rd);
      chk({nm, " sram_ce"},    32'(sram_ce),    32'(ce));
      chk({nm, " sram_we"},    32'(sram_we),    32'(we));
      chk({nm, " sram_addr"},  32'(sram_addr),  32'(sa));
      chk({nm, " sram_wdata"}, sram_wdata,      wd);
      chk({nm, " sram_wbe"},   32'(sram_wbe),   32'(be));
   endtask

   task automatic cyc(input string nm, input logic [1:0] t, input logic w, input logic [2:0] s,
                      input logic [31:0] a, input logic [31:0] d, input logic rdy,
                      input logic [1:0] resp, input logic [31:0] rd, input logic ce,
                      input logic we, input logic [ADDR_W-1:0] sa, input logic [31:0] wd,
                      input logic [3:0] be);
      drive(t, w, s, a, d);
      @(negedge cpu_clk);
      chk_out(nm, rdy, resp, rd, ce, we, sa, wd, be);
      tick();
   endtask

   initial begin
      pad_cpu_rst_b = 1'b0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      bus.hburst = 3'b000; bus.hprot = 4'b0000;
      drive(T_ID, 1'b0, 3'd2, 32'h0, 32'h0);
      #2;
      chk_out("reset", 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, '0, 32'h0, 4'h0);

      preload(14'd8,  32'h11223344);
      preload(14'd2,  32'h55667788);
      preload(14'd12, 32'hCAFEF00D);
      pad_cpu_rst_b = 1'b1;
      tick();

      //                t      w  s  addr     hwdata        rdy hrdata     ce we sa      wdata        wbe
      // word write, idle x2, read back
      vt.push_back(v(T_NS,   1, 2, 32'h10, 32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'hDEADBEEF, 1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h0,        1, 1, 14'h4,  32'hDEADBEEF, 4'hF));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_NS,   0, 2, 32'h10, 32'h0,        1, 32'h0,        1, 0, 14'h4,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'hDEADBEEF, 0, 0, 14'h0,  32'h0,        4'h0));
      // byte write then immediate word read: lane forwarding
      vt.push_back(v(T_NS,   1, 0, 32'h21, 32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_NS,   0, 2, 32'h20, 32'h0000AB00, 1, 32'h0,        1, 0, 14'h8,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h1122AB44, 1, 1, 14'h8,  32'h0000AB00, 4'h2));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      // write, write, read: one wait state, order drain@0, read@8, drain@4
      vt.push_back(v(T_NS,   1, 2, 32'h0,  32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_NS,   1, 2, 32'h4,  32'hA0A0A0A0, 1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_NS,   0, 2, 32'h8,  32'hB1B1B1B1, 0, 32'h0,        1, 1, 14'h0,  32'hA0A0A0A0, 4'hF));
      vt.push_back(v(T_NS,   0, 2, 32'h8,  32'hB1B1B1B1, 1, 32'h0,        1, 0, 14'h2,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h55667788, 1, 1, 14'h1,  32'hB1B1B1B1, 4'hF));
      vt.push_back(v(T_NS,   0, 2, 32'h4,  32'h0,        1, 32'h0,        1, 0, 14'h1,  32'h0,        4'h0));
      vt.push_back(v(T_NS,   0, 2, 32'h0,  32'h0,        1, 32'hB1B1B1B1, 1, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'hA0A0A0A0, 0, 0, 14'h0,  32'h0,        4'h0));
      // halfword write, then read; BUSY is not an access
      vt.push_back(v(T_NS,   1, 1, 32'h22, 32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'hBEEF0000, 1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h0,        1, 1, 14'h8,  32'hBEEF0000, 4'hC));
      vt.push_back(v(T_NS,   0, 2, 32'h20, 32'h0,        1, 32'h0,        1, 0, 14'h8,  32'h0,        4'h0));
      vt.push_back(v(T_BUSY, 0, 2, 32'h20, 32'h0,        1, 32'hBEEFAB44, 0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      // back-to-back writes: drain and load in the same cycle
      vt.push_back(v(T_NS,   1, 2, 32'h40, 32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_SQ,   1, 2, 32'h44, 32'h11111111, 1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h22222222, 1, 32'h0,        1, 1, 14'h10, 32'h11111111, 4'hF));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h0,        1, 1, 14'h11, 32'h22222222, 4'hF));
      vt.push_back(v(T_NS,   0, 2, 32'h40, 32'h0,        1, 32'h0,        1, 0, 14'h10, 32'h0,        4'h0));
      vt.push_back(v(T_SQ,   0, 2, 32'h44, 32'h0,        1, 32'h11111111, 1, 0, 14'h11, 32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h22222222, 0, 0, 14'h0,  32'h0,        4'h0));
      // full-word forward over unwritten SRAM; top-lane byte write
      vt.push_back(v(T_NS,   1, 2, 32'h48, 32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_NS,   0, 2, 32'h48, 32'h5A5A5A5A, 1, 32'h0,        1, 0, 14'h12, 32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h5A5A5A5A, 1, 1, 14'h12, 32'h5A5A5A5A, 4'hF));
      vt.push_back(v(T_NS,   1, 0, 32'h27, 32'h0,        1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h77000000, 1, 32'h0,        0, 0, 14'h0,  32'h0,        4'h0));
      vt.push_back(v(T_ID,   0, 2, 32'h0,  32'h0,        1, 32'h0,        1, 1, 14'h9,  32'h77000000, 4'h8));

      for (int i = 0; i < vt.size(); i++) begin
         cyc($sformatf("vec%0d", i), vt[i].t, vt[i].w, vt[i].s, vt[i].a, vt[i].d,
             vt[i].rdy, 2'b00, vt[i].rd, vt[i].ce, vt[i].we, vt[i].sa, vt[i].wd, vt[i].be);
      end

`ifdef CPU_AHB_SRAM_ERR_RESP_EN
      cyc("err_rd_addr", T_NS, 0, 2, 32'h2,     32'h0,      1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("err_rd_e1",   T_ID, 0, 2, 32'h0,     32'h0,      0, 2'b01, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("err_rd_e2",   T_ID, 0, 2, 32'h0,     32'h0,      1, 2'b01, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("ok_rd_addr",  T_NS, 0, 2, 32'h20,    32'h0,      1, 2'b00, 32'h0, 1, 0, 14'h8, 32'h0, 4'h0);
      cyc("ok_rd_data",  T_ID, 0, 2, 32'h0,     32'h0,      1, 2'b00, 32'hBEEFAB44, 0, 0, '0, 32'h0, 4'h0);
      cyc("err_wr_addr", T_NS, 1, 2, 32'h10020, 32'h0,      1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("err_wr_e1",   T_ID, 0, 2, 32'h0,     32'h12345678, 0, 2'b01, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("err_b2b_e2",  T_NS, 0, 1, 32'h21,    32'h0,      1, 2'b01, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("err_b2b_e1",  T_ID, 0, 2, 32'h0,     32'h0,      0, 2'b01, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("err_b2b_e2b", T_ID, 0, 2, 32'h0,     32'h0,      1, 2'b01, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("err_done",    T_ID, 0, 2, 32'h0,     32'h0,      1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
`else
      cyc("mis_rd_addr", T_NS, 0, 2, 32'h2,     32'h0,      1, 2'b00, 32'h0, 1, 0, 14'h0, 32'h0, 4'h0);
      cyc("alias_addr",  T_NS, 0, 2, 32'h10020, 32'h0,      1, 2'b00, 32'hA0A0A0A0, 1, 0, 14'h8, 32'h0, 4'h0);
      cyc("alias_data",  T_ID, 0, 2, 32'h0,     32'h0,      1, 2'b00, 32'hBEEFAB44, 0, 0, '0, 32'h0, 4'h0);
      cyc("sz3_addr",    T_NS, 1, 3, 32'h50,    32'h0,      1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("sz3_data",    T_ID, 0, 2, 32'h0,     32'h0F0F0F0F, 1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("sz3_drain",   T_ID, 0, 2, 32'h0,     32'h0,      1, 2'b00, 32'h0, 1, 1, 14'h14, 32'h0F0F0F0F, 4'hF);
      cyc("mis_h_addr",  T_NS, 1, 1, 32'h23,    32'h0,      1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("mis_h_data",  T_ID, 0, 2, 32'h0,     32'hA5A50000, 1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("mis_h_drain", T_ID, 0, 2, 32'h0,     32'h0,      1, 2'b00, 32'h0, 1, 1, 14'h8, 32'hA5A50000, 4'hC);
`endif

      // Reset while a write sits in the buffer: it must never reach the SRAM.
      cyc("rst_wr_addr", T_NS, 1, 2, 32'h30, 32'h0,      1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      cyc("rst_wr_data", T_ID, 0, 2, 32'h0,  32'h99999999, 1, 2'b00, 32'h0, 0, 0, '0, 32'h0, 4'h0);
      chk_out("rst_pending", 1'b1, 2'b00, 32'h0, 1'b1, 1'b1, 14'hC, 32'h99999999, 4'hF);
      pad_cpu_rst_b = 1'b0;
      #1;
      chk_out("rst_mid", 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
      tick();
      tick();
      pad_cpu_rst_b = 1'b1;
      cyc("rst_rd_addr", T_NS, 0, 2, 32'h30, 32'h0, 1, 2'b00, 32'h0, 1, 0, 14'hC, 32'h0, 4'h0);
      cyc("rst_rd_data", T_ID, 0, 2, 32'h0,  32'h0, 1, 2'b00, 32'hCAFEF00D, 0, 0, '0, 32'h0, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/cpu_ahb_sram_slave.md
# cpu_ahb_sram_slave

AHB-Lite slave that terminates the CPU subsystem system bus (biu_pad_* / pad_biu_*) onto a single-port synchronous SRAM. Reads are zero-wait; writes are posted into a one-entry write buffer that drains to SRAM in cycles with no read. Read data is forwarded from the buffer when it overlaps a pending write. An optional two-cycle ERROR response is returned for illegal transfers.

## Interface
- ADDR_W, 14: SRAM word-address width (2^ADDR_W 32-bit words).
- REGION_W, 20: byte-address width of the region decoded by hsel; bits [REGION_W-1:ADDR_W+2] must be zero for an in-range access.
- cpu_clk  in  1  single clock, rising edge.
- pad_cpu_rst_b  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select from the bus decoder.
- haddr  in  32  address-phase address.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  0 byte, 1 half, 2 word.
- hburst, hprot  in  3, 4  ignored.
- hwdata  in  32  write data, data phase.
- hreadyin  in  1  bus HREADY (previous transfer complete).
- hrdata  out  32  full-word read data; the CPU side extracts lanes.
- hready  out  1  transfer-complete / wait-state.
- hresp  out  2  00 OKAY, 01 ERROR.
- sram_ce  out  1  SRAM access this cycle.
- sram_we  out  1  write strobe (with sram_ce).
- sram_addr  out  ADDR_W  word address.
- sram_wdata  out  32  write data.
- sram_wbe  out  4  byte enables.
- sram_rdata  in  32  read data, valid 1 cycle after a read access.

## Operation
- Accepted transfer: hsel & hreadyin & htrans[1] & hready. BUSY and IDLE get an OKAY zero-wait response.
- Byte enables:
  - size 0: 4'b0001 << haddr[1:0].
  - size 1: 4'b0011 << {haddr[1],1'b0}.
  - size 2: 4'b1111.
- Word address is haddr[ADDR_W+1:2].
- Read: in the accepted address-phase cycle, drive sram_ce=1, sram_we=0, sram_addr from haddr (combinational). In the data phase, hrdata = sram_rdata, with each lane replaced from the buffer when the buffer is valid, its word address matches, and its byte enable for that lane is set. Merge uses the buffer register contents of that cycle. hrdata = 32'h0 outside read data phases.
- Write: the address phase captures the word address and byte enables. The data phase loads hwdata and those fields into the buffer and sets buf_vld.
- Drain: when buf_vld and no read is issued this cycle, drive sram_ce=1, sram_we=1, and the buffer address, data and byte enables, then clear buf_vld. Load and drain in the same cycle is allowed; the old entry drains and the new entry loads.
- Conflict: a write data phase with buf_vld and no drain possible (a read address phase overlaps) causes:
  - hready=0 for one cycle;
  - the drain is performed in that cycle, since the read address phase is not accepted while hready=0;
  - the next cycle loads the buffer and asserts hready=1.
- The SRAM port serves one access per cycle. Priority: read issue, then drain.
- Reset mid-operation discards the buffered write.

## Timing
- Reset values:
  - hready=1, hresp=00, hrdata=0;
  - sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0, sram_wbe=0;
  - buf_vld=0; FSM in OKAY.
- Read latency: data is valid in the cycle after the address phase, with zero wait states.
- Write: zero wait states. The only exception is the conflict case, which adds 1 wait state.
- Response FSM states and transitions:
  - OKAY → ERR1 on an accepted illegal transfer.
  - ERR1 (hready=0, hresp=01) → ERR2.
  - ERR2 (hready=1, hresp=01) → OKAY, or → ERR1 if another illegal transfer is accepted in ERR2.
- Illegal transfers make no SRAM access and perform no buffer load.

## Configuration
- CPU_AHB_SRAM_ERR_RESP_EN defined: a transfer is illegal if any of the following holds, and gets the two-cycle ERROR response:
  - hsize>2;
  - hsize=1 with haddr[0]=1;
  - hsize=2 with haddr[1:0]≠0;
  - haddr[REGION_W-1:ADDR_W+2]≠0.
- Not defined:
  - hresp is tied to 00 and the ERR states are removed;
  - upper address bits are ignored, so the SRAM aliases;
  - hsize>2 is treated as a word access;
  - misaligned enables are the shifted masks above, truncated to 4 bits.

## Test plan
- Write word 0xDEADBEEF @0x10, then idle 2 cycles, then read @0x10 → one drain with sram_we=1 and wbe=1111 at word 4; read returns 0xDEADBEEF; hready stays 1 throughout.
- Write byte 0xAB @0x21 (wbe=0010), then immediately read word @0x20 with SRAM holding 0x11223344 → hrdata=0x1122AB44, zero waits.
- Write @0x0, then write @0x4, then read @0x8 back-to-back → exactly one hready=0 cycle, during the data phase of write @0x4; SRAM access order is drain @0x0, read @0x8, drain @0x4.
- Macro on, word read @0x2 → one cycle with hready=0/hresp=01, then one cycle with hready=1/hresp=01; no sram_ce; the following legal read returns OKAY.
- Assert pad_cpu_rst_b low while buf_vld=1 → all outputs take their reset values immediately; after release, a read of that address returns the old SRAM contents.
